// File: rtl/ram_4x8_pkg.sv
// ram_4x8_pkg: shared constants and the controller state encoding for the
// ram_4x8 storage hierarchy.
//   DATA_W  - RAM word width
//   ADDR_W  - RAM address width
//   DEPTH   - number of words (2**ADDR_W)
//   state_e - ram_4x8_ctrl state encoding; ST_ZERO is only reachable when
//             RAM_4X8_CTRL_ZEROIZE_EN is defined
package ram_4x8_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 2;
  localparam int DEPTH  = 1 << ADDR_W;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WR        = 3'd1,
    ST_RD_ADDR   = 3'd2,
    ST_RD_SAMPLE = 3'd3,
    ST_RSP       = 3'd4,
    ST_ZERO      = 3'd5
  } state_e;

endpackage

// File: rtl/ram_4x8_ctrl.sv
// ram_4x8_ctrl: request/response front-end for one ram_4x8 instance.
// Accepts single-word read/write requests over valid/ready, drives the RAM
// wr_en/addr/data_in lines from registers, and hides the RAM's registered
// read latency so read data is always coherent with earlier writes.
//
// Ports:
//   clk, rst_n             - clock, asynchronous active-low reset
//   req_valid/req_ready    - request handshake (accept when both high)
//   req_we/req_addr/req_wdata - request kind, word address, write data
//   rsp_valid/rsp_ready    - read response handshake
//   rsp_rdata              - read data, held until consumed
//   busy                   - high whenever the controller is not idle
//   ram_wr_en/ram_addr/ram_wdata - to RAM wr_en/addr/data_in
//   ram_rdata              - from RAM data_out
//
// Build option: define RAM_4X8_CTRL_ZEROIZE_EN to fill every word with
// ZERO_VAL (one word per cycle, addresses 0..3) after reset before the
// first request is accepted.
module ram_4x8_ctrl
  import ram_4x8_pkg::*;
#(
  parameter int                 DATA_W   = ram_4x8_pkg::DATA_W,
  parameter int                 ADDR_W   = ram_4x8_pkg::ADDR_W,
  parameter logic [DATA_W-1:0]  ZERO_VAL = {DATA_W{1'b0}}
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              busy,
  output logic              ram_wr_en,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

`ifdef RAM_4X8_CTRL_ZEROIZE_EN
  // Zeroize starts from address 0 with the fill word already on ram_wdata.
  localparam state_e            STATE_RST = ST_ZERO;
  localparam logic [DATA_W-1:0] WDATA_RST = ZERO_VAL;
`else
  // ZERO_VAL only matters for zeroize; without it the write-data reset is 0.
  localparam state_e            STATE_RST = ST_IDLE;
  localparam logic [DATA_W-1:0] WDATA_RST = ZERO_VAL ^ ZERO_VAL;
`endif

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q,  addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= STATE_RST;
      addr_q  <= {ADDR_W{1'b0}};
      wdata_q <= WDATA_RST;
      rdata_q <= {DATA_W{1'b0}};
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // Next-state and datapath update logic.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          wdata_d = req_wdata;
          state_d = req_we ? ST_WR : ST_RD_ADDR;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WR: begin
        state_d = ST_IDLE;
      end
      // One spare cycle lets the RAM's per-word output registers reload
      // after any write that landed on the accept edge.
      ST_RD_ADDR: begin
        state_d = ST_RD_SAMPLE;
      end
      ST_RD_SAMPLE: begin
        rdata_d = ram_rdata;
        state_d = ST_RSP;
      end
      ST_RSP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RSP;
        end
      end
`ifdef RAM_4X8_CTRL_ZEROIZE_EN
      // addr_q doubles as the fill pointer and wraps back to 0 on exit.
      ST_ZERO: begin
        wdata_d = ZERO_VAL;
        addr_d  = addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
        if (addr_q == {ADDR_W{1'b1}}) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_ZERO;
        end
      end
`endif
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // All outputs are decodes of registered state or direct register copies.
  assign req_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign rsp_valid = (state_q == ST_RSP);
  assign rsp_rdata = rdata_q;
`ifdef RAM_4X8_CTRL_ZEROIZE_EN
  assign ram_wr_en = (state_q == ST_WR) || (state_q == ST_ZERO);
`else
  assign ram_wr_en = (state_q == ST_WR);
`endif
  assign ram_addr  = addr_q;
  assign ram_wdata = wdata_q;

endmodule

// File: tb/tb_ram_4x8_ctrl.sv
// tb_ram_4x8_ctrl: directed self-checking bench for ram_4x8_ctrl. Contains a
// behavioural ram_4x8 (write on wr_en edge, per-word output registers
// reloaded every edge, muxed by addr) wired to the controller.
`timescale 1ns/1ps
module tb_ram_4x8_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic       req_we = 1'b0;
  logic [1:0] req_addr = 2'd0;
  logic [7:0] req_wdata = 8'h00;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [7:0] rsp_rdata;
  logic       busy;
  logic       ram_wr_en;
  logic [1:0] ram_addr;
  logic [7:0] ram_wdata;
  logic [7:0] ram_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  ram_4x8_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .busy      (busy),
    .ram_wr_en (ram_wr_en),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  always #5 clk = ~clk;

  // Behavioural ram_4x8.
  logic [7:0] mem  [4];
  logic [7:0] dreg [4];
  always @(posedge clk) begin
    if (ram_wr_en) mem[ram_addr] <= ram_wdata;
    for (int i = 0; i < 4; i++) dreg[i] <= mem[i];
  end
  assign ram_rdata = dreg[ram_addr];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (req_ready !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq("req_ready_wait", {31'd0, req_ready}, 32'd1);
  endtask

  task automatic check_reset_values();
    check_eq("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check_eq("rst_rsp_rdata", {24'd0, rsp_rdata}, 32'd0);
    check_eq("rst_ram_addr",  {30'd0, ram_addr},  32'd0);
    check_eq("rst_ram_wdata", {24'd0, ram_wdata}, 32'd0);
`ifdef RAM_4X8_CTRL_ZEROIZE_EN
    check_eq("rst_ram_wr_en", {31'd0, ram_wr_en}, 32'd1);
    check_eq("rst_busy",      {31'd0, busy},      32'd1);
    check_eq("rst_req_ready", {31'd0, req_ready}, 32'd0);
`else
    check_eq("rst_ram_wr_en", {31'd0, ram_wr_en}, 32'd0);
    check_eq("rst_busy",      {31'd0, busy},      32'd0);
    check_eq("rst_req_ready", {31'd0, req_ready}, 32'd1);
`endif
  endtask

  // Releases reset on a falling edge and checks the start-up sequence.
  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
`ifdef RAM_4X8_CTRL_ZEROIZE_EN
    check_eq("zero_addr0", {30'd0, ram_addr}, 32'd0);
    check_eq("zero_wr0",   {31'd0, ram_wr_en}, 32'd1);
    for (int i = 1; i < 4; i++) begin
      @(posedge clk); #1;
      check_eq("zero_addr", {30'd0, ram_addr}, i);
      check_eq("zero_wr",   {31'd0, ram_wr_en}, 32'd1);
      check_eq("zero_ready_low", {31'd0, req_ready}, 32'd0);
    end
    @(posedge clk); #1;
    check_eq("zero_done_wr", {31'd0, ram_wr_en}, 32'd0);
    check_eq("zero_done_ready", {31'd0, req_ready}, 32'd1);
`else
    check_eq("post_rst_ready", {31'd0, req_ready}, 32'd1);
`endif
  endtask

  task automatic do_write(input logic [1:0] a, input logic [7:0] d);
    wait_ready();
    req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_wdata = d;
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = 1'b0;
    check_eq("wr_en_high", {31'd0, ram_wr_en}, 32'd1);
    check_eq("wr_addr",    {30'd0, ram_addr},  {30'd0, a});
    check_eq("wr_data",    {24'd0, ram_wdata}, {24'd0, d});
    check_eq("wr_busy",    {31'd0, busy},      32'd1);
    @(posedge clk); #1;
    check_eq("wr_en_low",  {31'd0, ram_wr_en}, 32'd0);
    check_eq("wr_ready",   {31'd0, req_ready}, 32'd1);
  endtask

  task automatic do_read(input logic [1:0] a, input logic [7:0] exp, input int hold);
    wait_ready();
    req_valid = 1'b1; req_we = 1'b0; req_addr = a; req_wdata = 8'hEE;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check_eq("rd_e0_valid", {31'd0, rsp_valid}, 32'd0);
    check_eq("rd_e0_wr_en", {31'd0, ram_wr_en}, 32'd0);
    check_eq("rd_addr",     {30'd0, ram_addr},  {30'd0, a});
    @(posedge clk); #1;
    check_eq("rd_e1_valid", {31'd0, rsp_valid}, 32'd0);
    @(posedge clk); #1;
    check_eq("rd_e2_valid", {31'd0, rsp_valid}, 32'd1);
    check_eq("rd_data",     {24'd0, rsp_rdata}, {24'd0, exp});
    check_eq("rd_ready_low", {31'd0, req_ready}, 32'd0);
    for (int i = 0; i < hold; i++) begin
      // A stray write presented while the response waits must be ignored.
      req_valid = 1'b1; req_we = 1'b1; req_addr = 2'd0; req_wdata = 8'hBB;
      @(posedge clk); #1;
      check_eq("hold_valid", {31'd0, rsp_valid}, 32'd1);
      check_eq("hold_data",  {24'd0, rsp_rdata}, {24'd0, exp});
      check_eq("hold_ready", {31'd0, req_ready}, 32'd0);
      check_eq("hold_wr_en", {31'd0, ram_wr_en}, 32'd0);
    end
    req_valid = 1'b0; req_we = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check_eq("consume_valid", {31'd0, rsp_valid}, 32'd0);
    check_eq("consume_ready", {31'd0, req_ready}, 32'd1);
  endtask

  initial begin
    logic [7:0] exp_after_rst;
    #2;
    check_reset_values();
    repeat (2) @(posedge clk);
    release_reset();

    // Write then immediate read of the same address.
    do_write(2'd2, 8'hA5);
    do_read(2'd2, 8'hA5, 0);

    // Fill all words, read back in reverse order.
    do_write(2'd0, 8'h11);
    do_write(2'd1, 8'h22);
    do_write(2'd2, 8'h33);
    do_write(2'd3, 8'h44);
    do_read(2'd3, 8'h44, 0);
    do_read(2'd2, 8'h33, 0);
    do_read(2'd1, 8'h22, 0);
    do_read(2'd0, 8'h11, 0);

    // Back-pressure on the response for 5 cycles; addr 0 must survive the stray write.
    do_read(2'd0, 8'h11, 5);
    do_read(2'd0, 8'h11, 0);

    // Reset during RD_SAMPLE discards the read.
    do_write(2'd1, 8'h5A);
    wait_ready();
    req_valid = 1'b1; req_we = 1'b0; req_addr = 2'd1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check_reset_values();
    @(posedge clk); #1;
    check_eq("rst_hold_valid", {31'd0, rsp_valid}, 32'd0);
    release_reset();
    check_eq("post_rst_valid", {31'd0, rsp_valid}, 32'd0);
`ifdef RAM_4X8_CTRL_ZEROIZE_EN
    exp_after_rst = 8'h00;
`else
    exp_after_rst = 8'h5A;
`endif
    do_read(2'd1, exp_after_rst, 0);

`ifdef RAM_4X8_CTRL_ZEROIZE_EN
    // Preload with FF, pulse reset, everything reads back as zero.
    for (int i = 0; i < 4; i++) do_write(i[1:0], 8'hFF);
    do_read(2'd3, 8'hFF, 0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_values();
    release_reset();
    for (int i = 0; i < 4; i++) do_read(i[1:0], 8'h00, 0);
`endif

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
